// File: rtl/rf_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : rf_arb_pkg
// Brief  : Shared constants and write-entry type for the register-file
//          write arbiter.
// Rev    : 1.0  initial release
// ============================================================================
package rf_arb_pkg;

    localparam int REGW         = 2;
    localparam int WR_DW        = 8;
    localparam int SRC_WB       = 0;
    localparam int SRC_DM       = 1;
    localparam int SRC_DE       = 2;
    localparam int STALL_MARGIN = 3;

    // Field is 'addr' because 'reg' is a reserved word.
    typedef struct packed {
        logic [REGW-1:0]  addr;
        logic [WR_DW-1:0] data;
    } wr_entry_t;

endpackage
`default_nettype wire

// File: rtl/rf_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : rf_write_arbiter_if
// Brief  : Writer requests, decode read probe and Regfile write port bundle.
// Rev    : 1.0  initial release
// ============================================================================
interface rf_write_arbiter_if #(
    parameter int DW   = 8,
    parameter int NREG = 4
);
    logic                       wb_req;
    logic [rf_arb_pkg::REGW-1:0] wb_reg;
    logic [DW-1:0]              wb_data;
    logic                       dm_req;
    logic [rf_arb_pkg::REGW-1:0] dm_reg;
    logic [DW-1:0]              dm_data;
    logic                       de_req;
    logic [rf_arb_pkg::REGW-1:0] de_reg;
    logic [DW-1:0]              de_data;
    logic                       rd_valid;
    logic [rf_arb_pkg::REGW-1:0] rd_ra;
    logic [rf_arb_pkg::REGW-1:0] rd_rb;
    logic                       rf_we;
    logic [rf_arb_pkg::REGW-1:0] rf_waddr;
    logic [DW-1:0]              rf_wdata;
    logic [NREG-1:0]            pend;
    logic                       hazard;
    logic                       stall;
    logic                       ovf_err;

    modport master (
        output wb_req, wb_reg, wb_data, dm_req, dm_reg, dm_data,
               de_req, de_reg, de_data, rd_valid, rd_ra, rd_rb,
        input  rf_we, rf_waddr, rf_wdata, pend, hazard, stall, ovf_err
    );

    modport slave (
        input  wb_req, wb_reg, wb_data, dm_req, dm_reg, dm_data,
               de_req, de_reg, de_data, rd_valid, rd_ra, rd_rb,
        output rf_we, rf_waddr, rf_wdata, pend, hazard, stall, ovf_err
    );
endinterface
`default_nettype wire

// File: rtl/rf_write_arbiter_fifo.sv
`default_nettype none
// ============================================================================
// Module : rf_wr_fifo
// Brief  : Circular buffer accepting 0..3 pushes and at most one pop per cycle.
// Rev    : 1.0  initial release
// ============================================================================
module rf_wr_fifo
    import rf_arb_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  wire logic      clk,
    input  wire logic      reset,
    input  wire logic [1:0] push_cnt,
    input  wr_entry_t      push_data [3],
    input  wire logic      pop,
    output wr_entry_t      head,
    output logic [CW-1:0]  count,
    output logic [CW-1:0]  free
);
    localparam int PW = $clog2(DEPTH);

    wr_entry_t       r_mem [DEPTH];
    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;

    // Modulo wrap keeps the buffer correct for non power-of-two depths.
    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [31:0] k);
        logic [31:0] s;
        s = 32'(p) + k;
        return PW'(s % DEPTH);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= ptr_add(r_wr_ptr, 32'(push_cnt));
            if (pop) begin
                r_rd_ptr <= ptr_add(r_rd_ptr, 32'd1);
            end
            r_count <= r_count + CW'(push_cnt) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 3; i++) begin
                if (2'(i) < push_cnt) begin
                    r_mem[ptr_add(r_wr_ptr, 32'(i))] <= push_data[i];
                end
            end
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;
    assign free  = CW'(DEPTH) - r_count;

endmodule
`default_nettype wire

// File: rtl/rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module : rf_write_arbiter
// Brief  : Serialises WB/DM/DE register writes onto the single Regfile port,
//          tracks pending writes per register for decode hazard detection.
// Rev    : 1.0  initial release
// ============================================================================
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = WR_DW,
    parameter int NREG  = 4
) (
    input  wire logic         clk,
    input  wire logic         reset,
    rf_write_arbiter_if.slave bus
);
    localparam int CW   = $clog2(DEPTH + 1);
    localparam int CNTW = $clog2(DEPTH + 2);

    wr_entry_t         w_req_ent [3];
    logic [2:0]        w_req_v;
    wr_entry_t         w_ord [3];
    logic [1:0]        w_n_new;
    wr_entry_t         w_push [3];
    logic [1:0]        w_npush;
    logic [1:0]        w_accept;
    logic [CW:0]       w_space;
    logic              w_ovf;
    logic              w_pop;
    logic              w_sel_v;
    logic              w_bypass;
    wr_entry_t         w_sel;
    wr_entry_t         w_head;
    logic [CW-1:0]     w_count;
    logic [CW-1:0]     w_free;
    logic [CW-1:0]     w_count_nxt;
    logic [CNTW-1:0]   w_inc [NREG];
    logic [NREG-1:0]   w_dec;
    logic [NREG-1:0]   w_pend;

    logic              r_we;
    logic [REGW-1:0]   r_waddr;
    logic [DW-1:0]     r_wdata;
    logic              r_stall;
    logic              r_ovf;
    logic [CNTW-1:0]   r_cnt [NREG];

    // Compact the new requests into age order: WB oldest, DE youngest.
    always_comb begin
        w_req_v                 = '0;
        w_req_v[SRC_WB]         = bus.wb_req;
        w_req_v[SRC_DM]         = bus.dm_req;
        w_req_v[SRC_DE]         = bus.de_req;
        w_req_ent[SRC_WB]       = '{addr: bus.wb_reg, data: bus.wb_data};
        w_req_ent[SRC_DM]       = '{addr: bus.dm_reg, data: bus.dm_data};
        w_req_ent[SRC_DE]       = '{addr: bus.de_reg, data: bus.de_data};
        w_n_new                 = '0;
        for (int i = 0; i < 3; i++) begin
            w_ord[i] = '0;
        end
        for (int s = 0; s < 3; s++) begin
            if (w_req_v[s]) begin
                w_ord[w_n_new] = w_req_ent[s];
                w_n_new        = w_n_new + 2'd1;
            end
        end
    end

    always_comb begin
        w_pop    = (w_count != '0);
        w_sel_v  = 1'b0;
        w_bypass = 1'b0;
        w_sel    = '0;
        w_npush  = '0;
        for (int i = 0; i < 3; i++) begin
            w_push[i] = '0;
        end
        if (w_pop) begin
            w_sel_v = 1'b1;
            w_sel   = w_head;
            for (int i = 0; i < 3; i++) begin
                w_push[i] = w_ord[i];
            end
            w_npush = w_n_new;
        end else if (w_n_new != '0) begin
            w_sel_v   = 1'b1;
            w_bypass  = 1'b1;
            w_sel     = w_ord[0];
            w_push[0] = w_ord[1];
            w_push[1] = w_ord[2];
            w_npush   = w_n_new - 2'd1;
        end

        // Truncating the ordered push list drops the youngest requests first.
        w_space = {1'b0, w_free} + (CW+1)'(w_pop);
        w_ovf   = ((CW+1)'(w_npush) > w_space);
        if (w_ovf) begin
            w_accept = w_space[1:0];
        end else begin
            w_accept = w_npush;
        end
        w_count_nxt = w_count - CW'(w_pop) + CW'(w_accept);
    end

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            w_inc[r] = '0;
            w_dec[r] = r_we && (r_waddr == REGW'(r));
        end
        if (w_bypass) begin
            w_inc[w_sel.addr] = w_inc[w_sel.addr] + CNTW'(1);
        end
        for (int i = 0; i < 3; i++) begin
            if (2'(i) < w_accept) begin
                w_inc[w_push[i].addr] = w_inc[w_push[i].addr] + CNTW'(1);
            end
        end
    end

    rf_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push_cnt  (w_accept),
        .push_data (w_push),
        .pop       (w_pop),
        .head      (w_head),
        .count     (w_count),
        .free      (w_free)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_stall <= 1'b0;
            r_ovf   <= 1'b0;
            for (int r = 0; r < NREG; r++) begin
                r_cnt[r] <= '0;
            end
        end else begin
            r_we <= w_sel_v;
            if (w_sel_v) begin
                r_waddr <= w_sel.addr;
                r_wdata <= w_sel.data;
            end
            r_stall <= ((CW'(DEPTH) - w_count_nxt) < CW'(STALL_MARGIN));
            if (w_ovf) begin
                r_ovf <= 1'b1;
            end
            for (int r = 0; r < NREG; r++) begin
                r_cnt[r] <= r_cnt[r] + w_inc[r] - CNTW'(w_dec[r]);
            end
        end
    end

    // A register stays pending through its rf_we cycle; Regfile commits at that edge.
    always_comb begin
        w_pend = '0;
        for (int r = 0; r < NREG; r++) begin
            w_pend[r] = (r_cnt[r] != '0);
        end
    end

    assign bus.rf_we    = r_we;
    assign bus.rf_waddr = r_waddr;
    assign bus.rf_wdata = r_wdata;
    assign bus.pend     = w_pend;
    assign bus.hazard   = bus.rd_valid & (w_pend[bus.rd_ra] | w_pend[bus.rd_rb]);
    assign bus.stall    = r_stall;
    assign bus.ovf_err  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_rf_write_arbiter
// Brief  : Directed vector table, reset corner case and modelled random traffic.
// Rev    : 1.0  initial release
// ============================================================================
module tb_rf_write_arbiter;

    typedef struct {
        logic wb; logic [1:0] wr; logic [7:0] wd;
        logic dm; logic [1:0] dr; logic [7:0] dd;
        logic de; logic [1:0] er; logic [7:0] ed;
        logic rv; logic [1:0] ra; logic [1:0] rb;
        logic e_we; logic [1:0] e_wa; logic [7:0] e_wd;
        logic [3:0] e_pend; logic e_haz; logic e_stall; logic e_ovf;
    } vec_t;

    typedef struct {
        logic [1:0] a;
        logic [7:0] d;
    } ent_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    vec_t vecs [19];

    ent_t       mq [$];
    logic       m_we;
    logic [1:0] m_wa;
    logic [7:0] m_wd;
    logic       m_ovf;
    logic       m_stall;

    always #5 clk = ~clk;

    rf_write_arbiter_if #(.DW(8), .NREG(4)) bus ();

    rf_write_arbiter #(.DEPTH(4), .DW(8), .NREG(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%0h want=%0h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.wb_req = v.wb; bus.wb_reg = v.wr; bus.wb_data = v.wd;
        bus.dm_req = v.dm; bus.dm_reg = v.dr; bus.dm_data = v.dd;
        bus.de_req = v.de; bus.de_reg = v.er; bus.de_data = v.ed;
        bus.rd_valid = v.rv; bus.rd_ra = v.ra; bus.rd_rb = v.rb;
    endtask

    task automatic drive_idle();
        vec_t v;
        v = '{0,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0,0};
        drive(v);
    endtask

    // Reference: queue holds waiting writes; pend is whatever is queued or on the port.
    task automatic model_step(input vec_t v);
        ent_t lst [$];
        ent_t e;
        logic sv;
        e  = '{2'd0, 8'd0};
        sv = 1'b0;
        if (v.wb) lst.push_back('{v.wr, v.wd});
        if (v.dm) lst.push_back('{v.dr, v.dd});
        if (v.de) lst.push_back('{v.er, v.ed});
        if (mq.size() > 0) begin
            e = mq.pop_front(); sv = 1'b1;
        end else if (lst.size() > 0) begin
            e = lst.pop_front(); sv = 1'b1;
        end
        foreach (lst[i]) begin
            if (mq.size() < 4) mq.push_back(lst[i]);
            else m_ovf = 1'b1;
        end
        m_we = sv;
        if (sv) begin
            m_wa = e.a; m_wd = e.d;
        end
        m_stall = ((4 - mq.size()) < 3);
    endtask

    function automatic logic [3:0] model_pend();
        logic [3:0] p;
        p = '0;
        foreach (mq[i]) p[mq[i].a] = 1'b1;
        if (m_we) p[m_wa] = 1'b1;
        return p;
    endfunction

    initial begin
        vec_t v;
        logic [3:0] p;
        // wb,wr,wd, dm,dr,dd, de,er,ed, rv,ra,rb, we,wa,wdata, pend,haz,stall,ovf
        vecs[0]  = '{1,2,8'h3C, 0,0,8'h00, 0,0,8'h00, 0,0,0, 1,2,8'h3C, 4'b0100,0,0,0};
        vecs[1]  = '{0,0,8'h00, 0,0,8'h00, 0,0,8'h00, 0,0,0, 0,0,8'h00, 4'b0000,0,0,0};
        vecs[2]  = '{1,1,8'h11, 1,1,8'h22, 1,1,8'h33, 0,0,0, 1,1,8'h11, 4'b0010,0,1,0};
        vecs[3]  = '{0,0,8'h00, 0,0,8'h00, 0,0,8'h00, 0,0,0, 1,1,8'h22, 4'b0010,0,0,0};
        vecs[4]  = '{0,0,8'h00, 0,0,8'h00, 0,0,8'h00, 0,0,0, 1,1,8'h33, 4'b0010,0,0,0};
        vecs[5]  = '{0,0,8'h00, 0,0,8'h00, 0,0,8'h00, 0,0,0, 0,0,8'h00, 4'b0000,0,0,0};
        vecs[6]  = '{0,0,8'h00, 1,3,8'h5A, 0,0,8'h00, 1,3,0, 1,3,8'h5A, 4'b1000,1,0,0};
        vecs[7]  = '{0,0,8'h00, 0,0,8'h00, 0,0,8'h00, 1,3,0, 0,0,8'h00, 4'b0000,0,0,0};
        vecs[8]  = '{1,0,8'h01, 1,3,8'h02, 0,0,8'h00, 1,3,3, 1,0,8'h01, 4'b1001,1,0,0};
        vecs[9]  = '{0,0,8'h00, 0,0,8'h00, 0,0,8'h00, 1,0,0, 1,3,8'h02, 4'b1000,0,0,0};
        vecs[10] = '{0,0,8'h00, 0,0,8'h00, 0,0,8'h00, 1,1,3, 0,0,8'h00, 4'b0000,0,0,0};
        vecs[11] = '{1,0,8'hA0, 1,1,8'hA1, 1,2,8'hA2, 0,0,0, 1,0,8'hA0, 4'b0111,0,1,0};
        vecs[12] = '{1,3,8'hB0, 1,0,8'hB1, 1,1,8'hB2, 0,0,0, 1,1,8'hA1, 4'b1111,0,1,0};
        vecs[13] = '{1,2,8'hC0, 1,3,8'hC1, 1,0,8'hC2, 0,0,0, 1,2,8'hA2, 4'b1111,0,1,1};
        vecs[14] = '{0,0,8'h00, 0,0,8'h00, 0,0,8'h00, 0,0,0, 1,3,8'hB0, 4'b1111,0,1,1};
        vecs[15] = '{0,0,8'h00, 0,0,8'h00, 0,0,8'h00, 0,0,0, 1,0,8'hB1, 4'b0111,0,1,1};
        vecs[16] = '{0,0,8'h00, 0,0,8'h00, 0,0,8'h00, 0,0,0, 1,1,8'hB2, 4'b0110,0,0,1};
        vecs[17] = '{0,0,8'h00, 0,0,8'h00, 0,0,8'h00, 0,0,0, 1,2,8'hC0, 4'b0100,0,0,1};
        vecs[18] = '{0,0,8'h00, 0,0,8'h00, 0,0,8'h00, 0,0,0, 0,0,8'h00, 4'b0000,0,0,1};

        reset = 1'b1;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        check("rst_we",    0, 32'(bus.rf_we),   32'd0);
        check("rst_waddr", 0, 32'(bus.rf_waddr), 32'd0);
        check("rst_wdata", 0, 32'(bus.rf_wdata), 32'd0);
        check("rst_pend",  0, 32'(bus.pend),    32'd0);
        check("rst_stall", 0, 32'(bus.stall),   32'd0);
        check("rst_ovf",   0, 32'(bus.ovf_err), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            check("idle_we",   k, 32'(bus.rf_we), 32'd0);
            check("idle_pend", k, 32'(bus.pend),  32'd0);
        end

        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            @(posedge clk); #1;
            check("vec_we", i, 32'(bus.rf_we), 32'(vecs[i].e_we));
            if (vecs[i].e_we) begin
                check("vec_waddr", i, 32'(bus.rf_waddr), 32'(vecs[i].e_wa));
                check("vec_wdata", i, 32'(bus.rf_wdata), 32'(vecs[i].e_wd));
            end
            check("vec_pend",   i, 32'(bus.pend),    32'(vecs[i].e_pend));
            check("vec_hazard", i, 32'(bus.hazard),  32'(vecs[i].e_haz));
            check("vec_stall",  i, 32'(bus.stall),   32'(vecs[i].e_stall));
            check("vec_ovf",    i, 32'(bus.ovf_err), 32'(vecs[i].e_ovf));
        end

        // Reset with three queued writes and a request presented in the reset cycle.
        @(negedge clk);
        drive('{1,0,8'h71, 1,1,8'h72, 1,2,8'h73, 0,0,0, 0,0,0, 0,0,0,0});
        @(posedge clk); #1;
        check("r5_we0",    0, 32'(bus.rf_waddr), 32'd0);
        @(negedge clk);
        drive('{1,3,8'h74, 1,0,8'h75, 0,0,8'h00, 0,0,0, 0,0,0, 0,0,0,0});
        @(posedge clk); #1;
        check("r5_wdata",  0, 32'(bus.rf_wdata), 32'h72);
        check("r5_stall",  0, 32'(bus.stall),    32'd1);
        check("r5_ovf",    0, 32'(bus.ovf_err),  32'd1);
        @(negedge clk);
        reset = 1'b1;
        drive('{1,1,8'hEE, 0,0,8'h00, 0,0,8'h00, 0,0,0, 0,0,0, 0,0,0,0});
        @(posedge clk); #1;
        check("r5_we",     1, 32'(bus.rf_we),   32'd0);
        check("r5_pend",   1, 32'(bus.pend),    32'd0);
        check("r5_stall",  1, 32'(bus.stall),   32'd0);
        check("r5_ovf",    1, 32'(bus.ovf_err), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        drive_idle();
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("r5_stale_we",   k, 32'(bus.rf_we), 32'd0);
            check("r5_stale_pend", k, 32'(bus.pend),  32'd0);
        end

        // Legal random traffic: DM/DE only while the model says stall is low.
        m_we = 1'b0; m_wa = '0; m_wd = '0; m_ovf = 1'b0; m_stall = 1'b0;
        for (int c = 0; c < 260; c++) begin
            @(negedge clk);
            v = '{0,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0, 0,0,0,0};
            if (c < 250) begin
                v.wb = 1'($urandom_range(0, 1));
                v.dm = !m_stall && 1'($urandom_range(0, 1));
                v.de = !m_stall && 1'($urandom_range(0, 1));
                v.wr = 2'($urandom); v.dr = 2'($urandom); v.er = 2'($urandom);
                v.wd = 8'($urandom); v.dd = 8'($urandom); v.ed = 8'($urandom);
                v.rv = 1'($urandom_range(0, 1));
                v.ra = 2'($urandom); v.rb = 2'($urandom);
            end
            drive(v);
            model_step(v);
            p = model_pend();
            @(posedge clk); #1;
            check("rnd_we", c, 32'(bus.rf_we), 32'(m_we));
            if (m_we) begin
                check("rnd_waddr", c, 32'(bus.rf_waddr), 32'(m_wa));
                check("rnd_wdata", c, 32'(bus.rf_wdata), 32'(m_wd));
            end
            check("rnd_pend",   c, 32'(bus.pend),    32'(p));
            check("rnd_hazard", c, 32'(bus.hazard),  32'(v.rv & (p[v.ra] | p[v.rb])));
            check("rnd_stall",  c, 32'(bus.stall),   32'(m_stall));
            check("rnd_ovf",    c, 32'(bus.ovf_err), 32'(m_ovf));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
